db9md_pad_scanner: RTL and testbench



---
 rtl/db9md_pkg.sv | 45 ++++
 rtl/db9md_step_timer.sv | 39 +++
 rtl/db9md_pad_scanner.sv | 175 +++++++++++++++++
 tb/tb_db9md_pad_scanner.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/db9md_pkg.sv
// rtl/db9md_pkg.sv - shared step enum, button/pin indices and select helper for the DB9 pad scanner
package db9md_pkg;

    typedef enum logic [3:0] {
        ST_SETTLE,
        ST_S0,
        ST_S1,
        ST_S2,
        ST_S3,
        ST_S4,
        ST_S5,
        ST_S6,
        ST_S7,
        ST_IDLE
    } step_t;

    localparam int BTN_R     = 0;
    localparam int BTN_L     = 1;
    localparam int BTN_D     = 2;
    localparam int BTN_U     = 3;
    localparam int BTN_B     = 4;
    localparam int BTN_C     = 5;
    localparam int BTN_A     = 6;
    localparam int BTN_START = 7;
    localparam int BTN_MODE  = 8;
    localparam int BTN_X     = 9;
    localparam int BTN_Y     = 10;
    localparam int BTN_Z     = 11;

    localparam int PIN_UP    = 0;
    localparam int PIN_DOWN  = 1;
    localparam int PIN_LEFT  = 2;
    localparam int PIN_RIGHT = 3;
    localparam int PIN_TL    = 4;
    localparam int PIN_TR    = 5;

    // Odd protocol steps drive select low; everything else holds it high.
    function automatic logic mdsel_for(input step_t s);
        case (s)
            ST_S1, ST_S3, ST_S5, ST_S7: return 1'b0;
            default:                    return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/db9md_step_timer.sv
// rtl/db9md_step_timer.sv - reloading down-counter producing the per-step sampling strobe and idle-gap end
module db9md_step_timer #(
    parameter int STEP_CYCLES = 400,
    parameter int IDLE_CYCLES = 80000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic load_idle,
    output logic step_last,
    output logic idle_done
);

    localparam int MAXC = (IDLE_CYCLES > STEP_CYCLES) ? IDLE_CYCLES : STEP_CYCLES;
    localparam int CW   = $clog2(MAXC);
    localparam logic [CW-1:0] STEP_LOAD = CW'(STEP_CYCLES - 1);
    localparam logic [CW-1:0] IDLE_LOAD = CW'(IDLE_CYCLES - 1);

    logic [CW-1:0] count;
    logic          in_idle;
    logic          at_zero;

    assign at_zero   = (count == '0);
    assign step_last = at_zero & ~in_idle;
    assign idle_done = at_zero & in_idle;

    // load_idle is only looked at on the wrap cycle, so it picks the next period's length.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count   <= STEP_LOAD;
            in_idle <= 1'b0;
        end else if (at_zero) begin
            count   <= load_idle ? IDLE_LOAD : STEP_LOAD;
            in_idle <= load_idle;
        end else begin
            count   <= count - 1'b1;
        end
    end

endmodule

// File: rtl/db9md_pad_scanner.sv
// rtl/db9md_pad_scanner.sv - two-player Mega Drive 3/6-button DB9 scanner; DB9MD_DEGLITCH_EN enables two-scan commit filter
module db9md_pad_scanner
    import db9md_pkg::*;
#(
    parameter int STEP_CYCLES = 400,
    parameter int IDLE_CYCLES = 80000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [5:0]  joy_in,
    output logic        joy_split,
    output logic        joy_mdsel,
    output logic [11:0] joystick1,
    output logic [11:0] joystick2,
    output logic [1:0]  six_btn
);

    logic [5:0]  sync1;
    logic [5:0]  pins;
    logic [5:0]  pressed;
    step_t       state;
    step_t       state_next;
    logic        player;
    logic        player_next;
    logic        step_last;
    logic        idle_done;
    logic        load_idle;
    logic [11:0] scan_word;
    logic        present;
    logic        six;
    logic        commit;
    logic        stable;
    logic [11:0] final_word;
    logic        final_six;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync1 <= '1;
            pins  <= '1;
        end else begin
            sync1 <= joy_in;
            pins  <= sync1;
        end
    end

    assign pressed = ~pins;

    assign load_idle = (state == ST_S7) && player;

    db9md_step_timer #(
        .STEP_CYCLES(STEP_CYCLES),
        .IDLE_CYCLES(IDLE_CYCLES)
    ) u_timer (
        .clk      (clk),
        .reset_n  (reset_n),
        .load_idle(load_idle),
        .step_last(step_last),
        .idle_done(idle_done)
    );

    always_comb begin
        state_next  = state;
        player_next = player;
        case (state)
            ST_IDLE: begin
                if (idle_done) begin
                    state_next  = ST_SETTLE;
                    player_next = 1'b0;
                end
            end
            ST_S7: begin
                if (step_last) begin
                    state_next  = player ? ST_IDLE : ST_SETTLE;
                    player_next = 1'b1;
                end
            end
            default: begin
                if (step_last) state_next = step_t'(4'(state) + 4'd1);
            end
        endcase
    end

    // Select and split are registered from the next state so the pad pins never see decode glitches.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= ST_SETTLE;
            player    <= 1'b0;
            joy_mdsel <= 1'b1;
            joy_split <= 1'b0;
        end else begin
            state     <= state_next;
            player    <= player_next;
            joy_mdsel <= mdsel_for(state_next);
            joy_split <= (state_next == ST_IDLE) ? 1'b1 : player_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            scan_word <= '0;
            present   <= 1'b0;
            six       <= 1'b0;
        end else if (step_last) begin
            case (state)
                ST_SETTLE: scan_word <= '0;
                ST_S0: begin
                    scan_word[BTN_U] <= pressed[PIN_UP];
                    scan_word[BTN_D] <= pressed[PIN_DOWN];
                    scan_word[BTN_L] <= pressed[PIN_LEFT];
                    scan_word[BTN_R] <= pressed[PIN_RIGHT];
                    scan_word[BTN_B] <= pressed[PIN_TL];
                    scan_word[BTN_C] <= pressed[PIN_TR];
                end
                ST_S1: begin
                    scan_word[BTN_A]     <= pressed[PIN_TL];
                    scan_word[BTN_START] <= pressed[PIN_TR];
                    present              <= pressed[PIN_LEFT] & pressed[PIN_RIGHT];
                end
                ST_S5: six <= &pressed[PIN_RIGHT:PIN_UP];
                ST_S6: begin
                    if (six) begin
                        scan_word[BTN_Z]    <= pressed[PIN_UP];
                        scan_word[BTN_Y]    <= pressed[PIN_DOWN];
                        scan_word[BTN_X]    <= pressed[PIN_LEFT];
                        scan_word[BTN_MODE] <= pressed[PIN_RIGHT];
                    end
                end
                default: ;
            endcase
        end
    end

    assign commit = step_last && (state == ST_S7);

    always_comb begin
        final_word = present ? scan_word : 12'h000;
        final_six  = present & six;
    end

`ifdef DB9MD_DEGLITCH_EN
    logic [12:0] prev1;
    logic [12:0] prev2;

    assign stable = ({final_six, final_word} == (player ? prev2 : prev1));

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            prev1 <= '0;
            prev2 <= '0;
        end else if (commit) begin
            if (player) prev2 <= {final_six, final_word};
            else        prev1 <= {final_six, final_word};
        end
    end
`else
    assign stable = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            joystick1 <= '0;
            joystick2 <= '0;
            six_btn   <= '0;
        end else if (commit && stable) begin
            if (player) begin
                joystick2  <= final_word;
                six_btn[1] <= final_six;
            end else begin
                joystick1  <= final_word;
                six_btn[0] <= final_six;
            end
        end
    end

endmodule

// File: tb/tb_db9md_pad_scanner.sv
// tb/tb_db9md_pad_scanner.sv - directed table-driven bench with behavioural 3/6-button pad models
module tb_db9md_pad_scanner;

    localparam int STEP    = 8;
    localparam int IDLE    = 64;
    localparam int FRAME   = 2 * 9 * STEP + IDLE;
    localparam int TIMEOUT = 32;
`ifdef DB9MD_DEGLITCH_EN
    localparam bit DG = 1'b1;
`else
    localparam bit DG = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic [5:0]  joy_in;
    logic        joy_split;
    logic        joy_mdsel;
    logic [11:0] joystick1;
    logic [11:0] joystick2;
    logic [1:0]  six_btn;

    logic [1:0]  pad_type [2];
    logic [11:0] pad_btn  [2];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    db9md_pad_scanner #(
        .STEP_CYCLES(STEP),
        .IDLE_CYCLES(IDLE)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .joy_in   (joy_in),
        .joy_split(joy_split),
        .joy_mdsel(joy_mdsel),
        .joystick1(joystick1),
        .joystick2(joystick2),
        .six_btn  (six_btn)
    );

    // Pad pins {TR,TL,Right,Left,Down,Up}, active low; type 0 none, 1 three-button, 2 six-button.
    function automatic logic [5:0] pins_fn(input logic [1:0] t, input logic [11:0] b,
                                           input logic sel, input int n);
        if (t == 2'd0) return 6'h3F;
        if (sel) begin
            if (t == 2'd2 && n == 3) return ~{b[5], b[4], b[8], b[9], b[10], b[11]};
            return ~{b[5], b[4], b[0], b[1], b[2], b[3]};
        end
        if (t == 2'd2 && n == 3) return {~b[7], ~b[6], 4'b0000};
        if (t == 2'd2 && n == 4) return {~b[7], ~b[6], 4'b1111};
        return {~b[7], ~b[6], 2'b00, ~b[2], ~b[3]};
    endfunction

    for (genvar g = 0; g < 2; g++) begin : pad
        logic       sel;
        logic       prev_sel = 1'b1;
        int         nlow = 0;
        int         quiet = 0;
        logic [5:0] pp;

        assign sel = (int'(joy_split) == g) ? joy_mdsel : 1'b1;

        always @(posedge clk) begin
            if (sel != prev_sel) begin
                quiet <= 0;
                if (prev_sel && !sel) nlow <= nlow + 1;
            end else begin
                if (quiet < 1000) quiet <= quiet + 1;
                if (quiet >= TIMEOUT) nlow <= 0;
            end
            prev_sel <= sel;
        end

        assign pp = pins_fn(pad_type[g], pad_btn[g], sel, nlow);
    end

    assign joy_in = joy_split ? pad[1].pp : pad[0].pp;

    typedef struct {
        logic [1:0]  t1;
        logic [11:0] b1;
        logic [1:0]  t2;
        logic [11:0] b2;
        logic [11:0] e1;
        logic [11:0] e2;
        logic [1:0]  esix;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic wait_split_rise();
        logic prev;
        int   n;
        prev = joy_split;
        n = 0;
        while (n < 3 * FRAME) begin
            @(negedge clk);
            if (!prev && joy_split) return;
            prev = joy_split;
            n++;
        end
        checks++;
        errors++;
        $display("FAIL split_rise_timeout actual=none expected=rise");
    endtask

    task automatic set_pads(input logic [1:0] t1, input logic [11:0] b1,
                            input logic [1:0] t2, input logic [11:0] b2);
        pad_type[0] = t1;
        pad_btn[0]  = b1;
        pad_type[1] = t2;
        pad_btn[1]  = b2;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int bound;
        logic found;

        vecs[0] = '{2'd1, 12'h0C1, 2'd0, 12'h000, 12'h0C1, 12'h000, 2'b00};
        vecs[1] = '{2'd0, 12'h000, 2'd2, 12'h928, 12'h000, 12'h928, 2'b10};
        vecs[2] = '{2'd2, 12'h013, 2'd1, 12'h023, 12'h013, 12'h023, 2'b01};
        vecs[3] = '{2'd2, 12'hFFF, 2'd2, 12'hFFF, 12'hFFF, 12'hFFF, 2'b11};
        vecs[4] = '{2'd2, 12'h000, 2'd1, 12'h000, 12'h000, 12'h000, 2'b01};
        vecs[5] = '{2'd1, 12'h010, 2'd2, 12'h640, 12'h010, 12'h640, 2'b10};

        // Reset state and first select toggle
        set_pads(2'd0, 12'h000, 2'd0, 12'h000);
        reset_n = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("rst_mdsel", 12'(joy_mdsel), 12'h001);
        check("rst_split", 12'(joy_split), 12'h000);
        check("rst_j1", joystick1, 12'h000);
        check("rst_j2", joystick2, 12'h000);
        check("rst_six", 12'(six_btn), 12'h000);
        reset_n = 1'b1;
        n = 0;
        while (n < 100) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (!joy_mdsel) break;
        end
        check("first_toggle_cycle", 12'(n), 12'd16);

        for (int i = 0; i < 6; i++) begin
            set_pads(vecs[i].t1, vecs[i].b1, vecs[i].t2, vecs[i].b2);
            repeat (3 * FRAME) @(posedge clk);
            @(negedge clk);
            check($sformatf("vec%0d_j1", i), joystick1, vecs[i].e1);
            check($sformatf("vec%0d_j2", i), joystick2, vecs[i].e2);
            check($sformatf("vec%0d_six", i), 12'(six_btn), 12'(vecs[i].esix));
        end

        // No pad, then plug in a 3-button pad holding B right after a p1 commit
        set_pads(2'd0, 12'h000, 2'd0, 12'h000);
        repeat (3 * FRAME) @(posedge clk);
        @(negedge clk);
        check("nopad_j1", joystick1, 12'h000);
        wait_split_rise();
        set_pads(2'd1, 12'h010, 2'd0, 12'h000);
        bound = (DG ? 2 : 1) * (FRAME + 3);
        found = 1'b0;
        n = 0;
        while (n < bound) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (joystick1 == 12'h010) begin
                found = 1'b1;
                break;
            end
        end
        check("plug_in_within_frame", 12'(found), 12'h001);

        // Reset during S4 of player 2, then restart from SETTLE(p1)
        set_pads(2'd1, 12'h0C1, 2'd2, 12'h928);
        repeat (3 * FRAME) @(posedge clk);
        @(negedge clk);
        check("pre_rst_j2", joystick2, 12'h928);
        wait_split_rise();
        repeat (43) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("midrst_j1", joystick1, 12'h000);
        check("midrst_j2", joystick2, 12'h000);
        check("midrst_six", 12'(six_btn), 12'h000);
        check("midrst_mdsel", 12'(joy_mdsel), 12'h001);
        check("midrst_split", 12'(joy_split), 12'h000);
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        for (int k = 1; k <= 72; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (k == 15) check("restart_sel_high", 12'(joy_mdsel), 12'h001);
            if (k == 16) check("restart_sel_low", 12'(joy_mdsel), 12'h000);
            if (k == 71) check("restart_j1_before", joystick1, 12'h000);
            if (k == 72) begin
                check("restart_j1_commit", joystick1, DG ? 12'h000 : 12'h0C1);
                check("restart_split", 12'(joy_split), 12'h001);
            end
        end

        // B held for one scan, then for two scans
        set_pads(2'd1, 12'h000, 2'd0, 12'h000);
        repeat (3 * FRAME) @(posedge clk);
        @(negedge clk);
        check("glitch_base", joystick1, 12'h000);
        wait_split_rise();
        pad_btn[0] = 12'h010;
        wait_split_rise();
        check("glitch_one_scan", joystick1, DG ? 12'h000 : 12'h010);
        pad_btn[0] = 12'h000;
        wait_split_rise();
        check("glitch_released", joystick1, 12'h000);
        pad_btn[0] = 12'h010;
        wait_split_rise();
        check("hold_first_scan", joystick1, DG ? 12'h000 : 12'h010);
        wait_split_rise();
        check("hold_second_scan", joystick1, 12'h010);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
